// File: rtl/wb_settings_master_pkg.sv
// Shared types for the settings-bus Wishbone initiator: FSM states and the
// queued command word {rd, addr, data}.
package wb_settings_master_pkg;
  localparam int SET_AW = 8;
  localparam int SET_DW = 32;
  localparam int CMD_W  = 1 + SET_AW + SET_DW;

  typedef enum logic {ST_IDLE = 1'b0, ST_BUS = 1'b1} state_e;

  typedef struct packed {
    logic              rd;
    logic [SET_AW-1:0] addr;
    logic [SET_DW-1:0] data;
  } cmd_t;

  // Word address -> byte address (32-bit words).
  function automatic logic [SET_AW+1:0] word2byte(input logic [SET_AW-1:0] a);
    return {a, 2'b00};
  endfunction
endpackage

// File: rtl/wb_settings_master_if.sv
// Command, Wishbone and readback signals of the settings initiator.
interface wb_settings_master_if #(
  parameter int AWIDTH = 16,
  parameter int DWIDTH = 32
);
  logic              set_stb;
  logic              set_rd;
  logic [7:0]        set_addr;
  logic [31:0]       set_data;
  logic              set_ready;
  logic              wb_cyc_o;
  logic              wb_stb_o;
  logic              wb_we_o;
  logic [AWIDTH-1:0] wb_adr_o;
  logic [DWIDTH-1:0] wb_dat_o;
  logic [DWIDTH-1:0] wb_dat_i;
  logic              wb_ack_i;
  logic              rb_stb;
  logic [31:0]       rb_data;
  logic              rb_err;
  logic              ovf;
  logic              busy;

  modport master (
    input  set_stb, set_rd, set_addr, set_data, wb_dat_i, wb_ack_i,
    output set_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           rb_stb, rb_data, rb_err, ovf, busy
  );

  modport slave (
    output set_stb, set_rd, set_addr, set_data, wb_dat_i, wb_ack_i,
    input  set_ready, wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o,
           rb_stb, rb_data, rb_err, ovf, busy
  );
endinterface

// File: rtl/wb_settings_master_fifo.sv
// Synchronous command FIFO with first-word fall-through read port.
// full_next_o is the full flag as it will be after the current edge.
module sb_cmd_fifo
  import wb_settings_master_pkg::*;
#(
  parameter int W        = CMD_W,
  parameter int DEPTH_LG = 2
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o,
  output logic         full_next_o
);
  localparam int DEPTH = 1 << DEPTH_LG;
  localparam logic [DEPTH_LG:0] FULL_CNT = {1'b1, {DEPTH_LG{1'b0}}};

  logic [W-1:0]        mem_q [DEPTH];
  logic [DEPTH_LG-1:0] wr_q, rd_q;
  logic [DEPTH_LG:0]   cnt_q, cnt_d;
  logic                do_push, do_pop;

  assign full_o      = (cnt_q == FULL_CNT);
  assign empty_o     = (cnt_q == '0);
  assign do_push     = push_i & ~full_o;
  assign do_pop      = pop_i & ~empty_o;
  assign full_next_o = (cnt_d == FULL_CNT);
  assign rdata_o     = mem_q[rd_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_push && !do_pop)      cnt_d = cnt_q + 1'b1;
    else if (!do_push && do_pop) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end
endmodule

// File: rtl/wb_settings_master.sv
// Settings-bus to Wishbone initiator: queues commands, runs one single cycle
// per command, reports read data or timeout aborts on the readback strobe.
module wb_settings_master
  import wb_settings_master_pkg::*;
#(
  parameter int AWIDTH   = 16,
  parameter int DWIDTH   = 32,
  parameter int DEPTH_LG = 2,
  parameter int TIMEOUT  = 255
) (
  input  logic                 wb_clk,
  input  logic                 wb_rst,
  wb_settings_master_if.master bus
);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cyc_q, cyc_d;
  logic              we_q, we_d;
  logic [AWIDTH-1:0] adr_q, adr_d;
  logic [DWIDTH-1:0] dat_q, dat_d;
  logic              rb_stb_q, rb_stb_d;
  logic [31:0]       rb_data_q, rb_data_d;
  logic              rb_err_q, rb_err_d;
  logic              set_ready_q, ovf_q;

  logic push, pop, full, empty, full_next;
  cmd_t push_cmd, head;

  // set_ready is a register, so it can only admit a push when there is room.
  assign push     = bus.set_stb & set_ready_q & ~full;
  assign push_cmd = {bus.set_rd, bus.set_addr, bus.set_data};

  sb_cmd_fifo #(.W(CMD_W), .DEPTH_LG(DEPTH_LG)) u_fifo (
    .clk_i       (wb_clk),
    .rst_i       (wb_rst),
    .push_i      (push),
    .wdata_i     (push_cmd),
    .pop_i       (pop),
    .rdata_o     (head),
    .full_o      (full),
    .empty_o     (empty),
    .full_next_o (full_next)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cyc_d     = cyc_q;
    we_d      = we_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    rb_stb_d  = 1'b0;
    rb_data_d = rb_data_q;
    rb_err_d  = rb_err_q;
    pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          cyc_d   = 1'b1;
          we_d    = ~head.rd;
          adr_d   = AWIDTH'(word2byte(head.addr));
          dat_d   = DWIDTH'(head.data);
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (bus.wb_ack_i) begin
          cyc_d   = 1'b0;
          state_d = ST_IDLE;
          if (!we_q) begin
            rb_stb_d  = 1'b1;
            rb_data_d = 32'(bus.wb_dat_i);
            rb_err_d  = 1'b0;
          end
        end else if (TIMEOUT != 0 && cnt_q == CNT_LAST) begin
          // Abort is reported for writes too, so software sees the lost command.
          cyc_d     = 1'b0;
          state_d   = ST_IDLE;
          rb_stb_d  = 1'b1;
          rb_data_d = '0;
          rb_err_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      rb_stb_q    <= 1'b0;
      rb_data_q   <= '0;
      rb_err_q    <= 1'b0;
      set_ready_q <= 1'b1;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      rb_stb_q    <= rb_stb_d;
      rb_data_q   <= rb_data_d;
      rb_err_q    <= rb_err_d;
      set_ready_q <= ~full_next;
      ovf_q       <= bus.set_stb & ~set_ready_q;
    end
  end

  assign bus.set_ready = set_ready_q;
  assign bus.wb_cyc_o  = cyc_q;
  assign bus.wb_stb_o  = cyc_q;
  assign bus.wb_we_o   = we_q;
  assign bus.wb_adr_o  = adr_q;
  assign bus.wb_dat_o  = dat_q;
  assign bus.rb_stb    = rb_stb_q;
  assign bus.rb_data   = rb_data_q;
  assign bus.rb_err    = rb_err_q;
  assign bus.ovf       = ovf_q;
  assign bus.busy      = ~empty | (state_q == ST_BUS);
endmodule

// File: tb/tb_wb_settings_master.sv
// Directed bench for wb_settings_master (TIMEOUT=8): write, read, overflow,
// timeout abort, reset mid-cycle and a registered ack responder.
module tb_wb_settings_master;
  logic wb_clk, wb_rst;
  int   checks = 0, failures = 0;

  wb_settings_master_if #(.AWIDTH(16), .DWIDTH(32)) bus ();

  wb_settings_master #(.AWIDTH(16), .DWIDTH(32), .DEPTH_LG(2), .TIMEOUT(8)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .bus    (bus)
  );

  initial wb_clk = 1'b0;
  always #5 wb_clk = ~wb_clk;

  bit          auto_ack = 0;
  int          acks = 0;
  logic [15:0] tx_adr[$];
  logic        tx_we[$];
  logic [31:0] tx_dat[$];
  logic [32:0] rb_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Registered responder: acks stb & ~ack, returns an address-derived read word.
  task automatic resp();
    if (bus.wb_stb_o && !bus.wb_ack_i) begin
      acks++;
      tx_adr.push_back(bus.wb_adr_o);
      tx_we.push_back(bus.wb_we_o);
      tx_dat.push_back(bus.wb_dat_o);
      bus.wb_dat_i = 32'hA500_0000 | 32'(bus.wb_adr_o);
      bus.wb_ack_i = 1'b1;
    end else begin
      bus.wb_ack_i = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge wb_clk);
    #1;
    if (bus.rb_stb) rb_q.push_back({bus.rb_err, bus.rb_data});
    if (auto_ack) resp();
  endtask

  task automatic cmd(input logic rd, input logic [7:0] a, input logic [31:0] d);
    bus.set_stb = 1'b1; bus.set_rd = rd; bus.set_addr = a; bus.set_data = d;
  endtask

  logic        c_rd[10];
  logic [7:0]  c_addr[10];
  logic [31:0] c_data[10];

  initial begin
    int n, sent, cyc_seen, rd_idx;
    wb_rst = 1'b1;
    bus.set_stb = 0; bus.set_rd = 0; bus.set_addr = '0; bus.set_data = '0;
    bus.wb_dat_i = '0; bus.wb_ack_i = 0;
    tick(); tick();
    check("rst_ready", bus.set_ready, 1);
    check("rst_cyc",   bus.wb_cyc_o, 0);
    check("rst_stb",   bus.wb_stb_o, 0);
    check("rst_rbstb", bus.rb_stb, 0);
    check("rst_ovf",   bus.ovf, 0);
    check("rst_busy",  bus.busy, 0);
    check("rst_adr",   bus.wb_adr_o, 0);
    wb_rst = 1'b0;
    tick();

    // Single write, ack one cycle after stb rises
    cmd(0, 8'h12, 32'hDEADBEEF);
    tick(); bus.set_stb = 0;
    check("w_busy_queued", bus.busy, 1);
    check("w_cyc_before",  bus.wb_cyc_o, 0);
    tick();
    check("w_stb",  bus.wb_stb_o, 1);
    check("w_adr",  bus.wb_adr_o, 16'h0048);
    check("w_we",   bus.wb_we_o, 1);
    check("w_dat",  bus.wb_dat_o, 32'hDEADBEEF);
    tick();
    check("w_stb_hold", bus.wb_stb_o, 1);
    bus.wb_ack_i = 1;
    tick(); bus.wb_ack_i = 0;
    check("w_cyc_after", bus.wb_cyc_o, 0);
    check("w_no_rb",     bus.rb_stb, 0);
    check("w_busy_after", bus.busy, 0);

    // Read, ack after 3 wait cycles
    cmd(1, 8'h05, 32'h0);
    tick(); bus.set_stb = 0;
    tick();
    check("r_adr", bus.wb_adr_o, 16'h0014);
    check("r_we",  bus.wb_we_o, 0);
    tick(); tick(); tick();
    check("r_stb_wait", bus.wb_stb_o, 1);
    bus.wb_ack_i = 1; bus.wb_dat_i = 32'hCAFEF00D;
    tick(); bus.wb_ack_i = 0; bus.wb_dat_i = '0;
    check("r_cyc_after", bus.wb_cyc_o, 0);
    check("r_rbstb", bus.rb_stb, 1);
    check("r_rbdata", bus.rb_data, 32'hCAFEF00D);
    check("r_rberr", bus.rb_err, 0);
    tick();
    check("r_rbstb_pulse", bus.rb_stb, 0);
    check("r_rbdata_hold", bus.rb_data, 32'hCAFEF00D);

    // Six back-to-back writes with ack withheld
    rb_q.delete();
    for (int i = 0; i < 6; i++) begin
      if (i == 4) check("o_ready_before_full", bus.set_ready, 1);
      if (i == 5) check("o_ready_full", bus.set_ready, 0);
      cmd(0, 8'(8'h20 + i), 32'h1000 + i);
      tick();
      if (i == 4) check("o_no_ovf_yet", bus.ovf, 0);
    end
    bus.set_stb = 0;
    check("o_ovf", bus.ovf, 1);
    check("o_busy", bus.busy, 1);
    tick();
    check("o_ovf_pulse", bus.ovf, 0);
    check("o_first_adr", bus.wb_adr_o, 16'h0080);
    tx_adr.delete(); tx_we.delete(); tx_dat.delete();
    acks = 0; auto_ack = 1;
    resp();
    n = 0;
    while (acks < 5 && n < 40) begin tick(); n++; end
    check("o_drain_in_time", (n < 40), 1);
    for (int i = 0; i < 6; i++) tick();
    auto_ack = 0; bus.wb_ack_i = 0;
    check("o_acks", acks, 5);
    check("o_tx_count", tx_adr.size(), 5);
    for (int i = 0; i < 5 && i < tx_adr.size(); i++) begin
      check($sformatf("o_adr%0d", i), tx_adr[i], 16'(32'h80 + 4 * i));
      check($sformatf("o_dat%0d", i), tx_dat[i], 32'h1000 + i);
    end
    check("o_no_rb", rb_q.size(), 0);
    check("o_idle", bus.busy, 0);

    // Write with no ack: timeout after 8 stb cycles
    cmd(0, 8'h33, 32'h55);
    tick(); bus.set_stb = 0;
    tick();
    n = 0;
    while (bus.wb_stb_o === 1'b1 && n < 20) begin n++; tick(); end
    check("t_stb_cycles", n, 8);
    check("t_rbstb", bus.rb_stb, 1);
    check("t_rberr", bus.rb_err, 1);
    check("t_rbdata", bus.rb_data, 0);
    cmd(1, 8'h07, 32'h0);
    tick(); bus.set_stb = 0;
    tick();
    check("t_next_adr", bus.wb_adr_o, 16'h001C);
    check("t_next_stb", bus.wb_stb_o, 1);
    bus.wb_ack_i = 1; bus.wb_dat_i = 32'h12345678;
    tick(); bus.wb_ack_i = 0;
    check("t_next_rbstb", bus.rb_stb, 1);
    check("t_next_rberr", bus.rb_err, 0);
    check("t_next_rbdata", bus.rb_data, 32'h12345678);
    tick();

    // Reset while stb high with two commands queued
    for (int i = 0; i < 3; i++) begin cmd(0, 8'(8'h40 + i), 32'h2000 + i); tick(); end
    bus.set_stb = 0;
    check("x_stb_pre", bus.wb_stb_o, 1);
    check("x_busy_pre", bus.busy, 1);
    rb_q.delete();
    wb_rst = 1;
    tick(); wb_rst = 0;
    check("x_cyc", bus.wb_cyc_o, 0);
    check("x_stb", bus.wb_stb_o, 0);
    check("x_ready", bus.set_ready, 1);
    check("x_busy", bus.busy, 0);
    cyc_seen = 0;
    for (int i = 0; i < 10; i++) begin tick(); if (bus.wb_cyc_o) cyc_seen++; end
    check("x_no_bus", cyc_seen, 0);
    check("x_no_rb", rb_q.size(), 0);

    // Ten random commands against the registered responder
    for (int i = 0; i < 10; i++) begin
      c_rd[i] = 1'($urandom_range(0, 1));
      c_addr[i] = 8'($urandom);
      c_data[i] = $urandom;
    end
    tx_adr.delete(); tx_we.delete(); tx_dat.delete(); rb_q.delete();
    acks = 0; auto_ack = 1; sent = 0; n = 0;
    while ((sent < 10 || acks < 10 || bus.busy) && n < 300) begin
      if (sent < 10 && bus.set_ready) begin
        cmd(c_rd[sent], c_addr[sent], c_data[sent]); sent++;
      end else bus.set_stb = 0;
      tick(); n++;
    end
    bus.set_stb = 0;
    tick(); tick();
    auto_ack = 0; bus.wb_ack_i = 0;
    check("s_in_time", (n < 300), 1);
    check("s_acks", acks, 10);
    rd_idx = 0;
    for (int i = 0; i < 10 && i < tx_adr.size(); i++) begin
      check($sformatf("s_adr%0d", i), tx_adr[i], {6'b0, c_addr[i], 2'b00});
      check($sformatf("s_we%0d", i), tx_we[i], !c_rd[i]);
      if (!c_rd[i]) check($sformatf("s_dat%0d", i), tx_dat[i], c_data[i]);
      else begin
        if (rd_idx < rb_q.size())
          check($sformatf("s_rb%0d", i), rb_q[rd_idx], {1'b0, 32'hA500_0000 | {22'b0, c_addr[i], 2'b00}});
        rd_idx++;
      end
    end
    check("s_rb_count", rb_q.size(), rd_idx);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
